apb_spi_slave_interface: RTL and testbench
==========================================

# apb_spi_slave_interface

APB slave front-end of the APB-to-SPI controller. It decodes 8-bit APB reads and writes into a small control/status/data register file that configures the SPI shifter. It reports a transfer-in-progress status (`tip_i`) from the shifter, and rejects illegal accesses with `PSLVERR_o`. It is zero-wait-state and sits between the system APB bus and the SPI core logic.

## Interface
- Parameters: none; address map and reset values are constants from the shared package.
- `PCLK` input 1: bus clock; all state updates on rising edge.
- `PRESET_n` input 1: one clock; reset is asynchronous and active-low.
- `PSEL_i` input 1: slave select.
- `PENABLE_i` input 1: access-phase marker.
- `PWRITE_i` input 1: 1 = write, 0 = read.
- `PADDR_i` input 3: register address.
- `PWDATA_i` input 8: write data.
- `tip_i` input 1: transfer in progress, from the SPI shifter.
- `PRDATA_o` output 8: read data.
- `PREADY_o` output 1: transfer complete, always zero-wait.
- `PSLVERR_o` output 1: transfer error, valid with `PREADY_o`.

## Operation
- Address map:
  - 0 = CR1, RW, reset 0x04.
  - 1 = CR2, RW, reset 0x00.
  - 2 = BR, RW, reset 0x00.
  - 3 = SR, RO, value {7'b0, tip_i}.
  - 5 = DR, RW, reset 0x00.
  - 4, 6, 7 are reserved and read as 0x00.
- All RW registers hold the full 8 bits; there is no bit masking. A readback returns exactly the value written.
- Access phase (ACC) = `PSEL_i & PENABLE_i`. A setup phase (`PSEL_i & !PENABLE_i`) has no side effects.
- Write commit: at the rising edge where ACC & `PWRITE_i` & no error, the selected register loads `PWDATA_i`.
- Error conditions, evaluated during ACC (`PSLVERR_o` = 1, no register changes):
  - any access to a reserved address;
  - a write to SR;
  - a write to DR while `tip_i` = 1.
- Writes to CR1, CR2 and BR are accepted regardless of `tip_i`.
- `PRDATA_o` is combinational. It equals the register selected by `PADDR_i` whenever `PWRITE_i` = 0, independent of `PSEL_i`/`PENABLE_i`, so data stays valid after the master drops PSEL. It is 0x00 when `PWRITE_i` = 1 or the address is reserved.
- `PREADY_o` = ACC, combinational.
- `PSLVERR_o` = ACC & error, combinational.

## Timing
- Reset (`PRESET_n` low, asynchronous): registers go to their reset values immediately. Outputs: `PREADY_o` = 0, `PSLVERR_o` = 0 (PSEL low), `PRDATA_o` = reset value of the addressed register.
- Write latency: the register is updated at the end of the access-phase cycle and is visible on `PRDATA_o` in the next cycle.
- Read latency: 0 cycles. It is a combinational path from `PADDR_i`, the registers and `tip_i`.
- Each transfer is 2 cycles (setup + access), with no wait states.
- Back-to-back transfers (access immediately followed by a new setup) are supported.
- Reset asserted mid-transfer aborts it. No partial write occurs, and registers return to reset values.
- If `tip_i` changes in the same cycle as a DR write access, the value sampled at that edge decides accept/reject.
- An X on `tip_i` only affects SR reads and DR writes.

## Structure
- Shared package `apb_spi_pkg` holds:
  - address constants `ADDR_CR1`=0, `ADDR_CR2`=1, `ADDR_BR`=2, `ADDR_SR`=3, `ADDR_DR`=5;
  - reset-value constants;
  - data width 8 and address width 3.
- Single flat module with no sub-modules. Internally it has three parts: the register file, the combinational read mux, and error/ready decode.

## Test plan
- Reset check: reset, then read addresses 0, 1, 2, 5. Required: 0x04, 0x00, 0x00, 0x00; `PREADY_o`/`PSLVERR_o` = 0 while idle.
- RW readback: write 0xA5 to addr 0, 0x3C to addr 1, 0xFF to addr 2, each followed by a read. Required: 0xA5, 0x3C, 0xFF, with `PSLVERR_o` = 0. `PRDATA_o` must still hold the value 5 ns after PSEL drops.
- SR: drive `tip_i` = 1, read addr 3 → 0x01; drive `tip_i` = 0 → 0x00. Write 0xFF to addr 3 → `PSLVERR_o` = 1 in the access phase, and SR is unchanged.
- DR gating: with `tip_i` = 1, write 0x5A to addr 5 → `PSLVERR_o` = 1 and DR stays 0x00. With `tip_i` = 0, write 0x5A → accepted, and a read returns 0x5A.
- Reserved: write 0x11 to addr 4, then read addr 6 → `PSLVERR_o` = 1 on both, read data 0x00, and no other register is changed.
- Reset mid-operation: write 0x77 to addr 2, then assert `PRESET_n` low during the access phase of a second write to addr 2. Required: BR reads 0x00 after release.

Source files
------------

// File: rtl/apb_spi_pkg.sv
// Shared constants for the APB-to-SPI controller: bus widths, register map and reset values.
package apb_spi_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_CR1 = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_CR2 = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_BR  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_SR  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_DR  = ADDR_W'(5);

    localparam logic [DATA_W-1:0] CR1_RST = DATA_W'(8'h04);
    localparam logic [DATA_W-1:0] CR2_RST = DATA_W'(8'h00);
    localparam logic [DATA_W-1:0] BR_RST  = DATA_W'(8'h00);
    localparam logic [DATA_W-1:0] DR_RST  = DATA_W'(8'h00);

endpackage

// File: rtl/apb_spi_slave_interface.sv
// Zero-wait APB slave holding the SPI control/status/data registers.
// Illegal accesses are flagged on PSLVERR_o and leave the register file untouched.
module apb_spi_slave_interface
    import apb_spi_pkg::*;
(
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              PSEL_i,
    input  logic              PENABLE_i,
    input  logic              PWRITE_i,
    input  logic [ADDR_W-1:0] PADDR_i,
    input  logic [DATA_W-1:0] PWDATA_i,
    input  logic              tip_i,
    output logic [DATA_W-1:0] PRDATA_o,
    output logic              PREADY_o,
    output logic              PSLVERR_o
);

    logic [DATA_W-1:0] cr1_q;
    logic [DATA_W-1:0] cr2_q;
    logic [DATA_W-1:0] br_q;
    logic [DATA_W-1:0] dr_q;

    logic acc_c;
    logic err_c;
    logic wr_en_c;

    assign acc_c = PSEL_i & PENABLE_i;

    // Access legality; DR writes are refused while the shifter is busy.
    always_comb begin
        err_c = 1'b0;
        case (PADDR_i)
            ADDR_CR1, ADDR_CR2, ADDR_BR: err_c = 1'b0;
            ADDR_SR:                     err_c = PWRITE_i;
            ADDR_DR:                     err_c = PWRITE_i & tip_i;
            default:                     err_c = 1'b1;
        endcase
    end

    assign wr_en_c   = acc_c & PWRITE_i & ~err_c;
    assign PREADY_o  = acc_c;
    assign PSLVERR_o = acc_c & err_c;

    // Register file
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            cr1_q <= CR1_RST;
            cr2_q <= CR2_RST;
            br_q  <= BR_RST;
            dr_q  <= DR_RST;
        end else if (wr_en_c) begin
            case (PADDR_i)
                ADDR_CR1: cr1_q <= PWDATA_i;
                ADDR_CR2: cr2_q <= PWDATA_i;
                ADDR_BR:  br_q  <= PWDATA_i;
                ADDR_DR:  dr_q  <= PWDATA_i;
                default:  ;
            endcase
        end
    end

    // Read mux is independent of PSEL/PENABLE so data survives PSEL dropping.
    always_comb begin
        PRDATA_o = '0;
        if (!PWRITE_i) begin
            case (PADDR_i)
                ADDR_CR1: PRDATA_o = cr1_q;
                ADDR_CR2: PRDATA_o = cr2_q;
                ADDR_BR:  PRDATA_o = br_q;
                ADDR_SR:  PRDATA_o = {{(DATA_W-1){1'b0}}, tip_i};
                ADDR_DR:  PRDATA_o = dr_q;
                default:  PRDATA_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_spi_slave_interface.sv
// Scoreboard bench for apb_spi_slave_interface: transfers queue their expected response,
// a monitor checks PRDATA_o/PSLVERR_o whenever the slave signals PREADY_o.
module tb_apb_spi_slave_interface;

    logic       PCLK;
    logic       PRESET_n;
    logic       PSEL_i;
    logic       PENABLE_i;
    logic       PWRITE_i;
    logic [2:0] PADDR_i;
    logic [7:0] PWDATA_i;
    logic       tip_i;
    logic [7:0] PRDATA_o;
    logic       PREADY_o;
    logic       PSLVERR_o;

    typedef struct {
        string      tag;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    apb_spi_slave_interface dut (
        .PCLK      (PCLK),
        .PRESET_n  (PRESET_n),
        .PSEL_i    (PSEL_i),
        .PENABLE_i (PENABLE_i),
        .PWRITE_i  (PWRITE_i),
        .PADDR_i   (PADDR_i),
        .PWDATA_i  (PWDATA_i),
        .tip_i     (tip_i),
        .PRDATA_o  (PRDATA_o),
        .PREADY_o  (PREADY_o),
        .PSLVERR_o (PSLVERR_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h required 0x%02h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one response per PREADY_o cycle while out of reset
    always @(negedge PCLK) begin
        if (PRESET_n && PREADY_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ready: got PREADY_o=1 required no transfer at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_rdata"}, PRDATA_o, e.rdata);
                check({e.tag, "_slverr"}, 8'(PSLVERR_o), 8'(e.err));
            end
        end
    end

    task automatic xfer(input string tag, input logic wr, input logic [2:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rd, input logic exp_err);
        exp_t e;
        e.tag   = tag;
        e.rdata = exp_rd;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(posedge PCLK); #1;
        PSEL_i    = 1'b1;
        PENABLE_i = 1'b0;
        PWRITE_i  = wr;
        PADDR_i   = addr;
        PWDATA_i  = wdata;
        @(posedge PCLK); #1;
        PENABLE_i = 1'b1;
        @(posedge PCLK); #1;
        PSEL_i    = 1'b0;
        PENABLE_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish before 100000ns");
        $fatal(1, "timeout");
    end

    initial begin
        PRESET_n  = 1'b0;
        PSEL_i    = 1'b0;
        PENABLE_i = 1'b0;
        PWRITE_i  = 1'b0;
        PADDR_i   = 3'd0;
        PWDATA_i  = 8'h00;
        tip_i     = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check("in_reset_cr1", PRDATA_o, 8'h04);
        PRESET_n = 1'b1;
        #2;
        check("idle_pready", 8'(PREADY_o), 8'h00);
        check("idle_pslverr", 8'(PSLVERR_o), 8'h00);

        // Reset values
        xfer("rst_cr1", 1'b0, 3'd0, 8'h00, 8'h04, 1'b0);
        xfer("rst_cr2", 1'b0, 3'd1, 8'h00, 8'h00, 1'b0);
        xfer("rst_br",  1'b0, 3'd2, 8'h00, 8'h00, 1'b0);
        xfer("rst_dr",  1'b0, 3'd5, 8'h00, 8'h00, 1'b0);

        // RW readback, with PRDATA_o held after PSEL drops
        xfer("wr_cr1", 1'b1, 3'd0, 8'hA5, 8'h00, 1'b0);
        xfer("rd_cr1", 1'b0, 3'd0, 8'h00, 8'hA5, 1'b0);
        #5 check("hold_cr1", PRDATA_o, 8'hA5);
        xfer("wr_cr2", 1'b1, 3'd1, 8'h3C, 8'h00, 1'b0);
        xfer("rd_cr2", 1'b0, 3'd1, 8'h00, 8'h3C, 1'b0);
        #5 check("hold_cr2", PRDATA_o, 8'h3C);
        xfer("wr_br", 1'b1, 3'd2, 8'hFF, 8'h00, 1'b0);
        xfer("rd_br", 1'b0, 3'd2, 8'h00, 8'hFF, 1'b0);
        #5 check("hold_br", PRDATA_o, 8'hFF);

        // Status register
        tip_i = 1'b1;
        xfer("rd_sr_tip1", 1'b0, 3'd3, 8'h00, 8'h01, 1'b0);
        tip_i = 1'b0;
        xfer("rd_sr_tip0", 1'b0, 3'd3, 8'h00, 8'h00, 1'b0);
        xfer("wr_sr", 1'b1, 3'd3, 8'hFF, 8'h00, 1'b1);
        xfer("rd_sr_after", 1'b0, 3'd3, 8'h00, 8'h00, 1'b0);

        // DR gated by tip_i; CR writes still accepted while busy
        tip_i = 1'b1;
        xfer("wr_dr_busy", 1'b1, 3'd5, 8'h5A, 8'h00, 1'b1);
        xfer("rd_dr_busy", 1'b0, 3'd5, 8'h00, 8'h00, 1'b0);
        xfer("wr_cr2_busy", 1'b1, 3'd1, 8'h3D, 8'h00, 1'b0);
        tip_i = 1'b0;
        xfer("wr_dr_idle", 1'b1, 3'd5, 8'h5A, 8'h00, 1'b0);
        xfer("rd_dr_idle", 1'b0, 3'd5, 8'h00, 8'h5A, 1'b0);

        // Reserved addresses
        xfer("wr_rsv4", 1'b1, 3'd4, 8'h11, 8'h00, 1'b1);
        xfer("rd_rsv6", 1'b0, 3'd6, 8'h00, 8'h00, 1'b1);
        xfer("rd_rsv7", 1'b0, 3'd7, 8'h00, 8'h00, 1'b1);
        xfer("chk_cr1", 1'b0, 3'd0, 8'h00, 8'hA5, 1'b0);
        xfer("chk_cr2", 1'b0, 3'd1, 8'h00, 8'h3D, 1'b0);
        xfer("chk_br",  1'b0, 3'd2, 8'h00, 8'hFF, 1'b0);
        xfer("chk_dr",  1'b0, 3'd5, 8'h00, 8'h5A, 1'b0);

        // Reset during the access phase of a second BR write
        xfer("wr_br77", 1'b1, 3'd2, 8'h77, 8'h00, 1'b0);
        xfer("rd_br77", 1'b0, 3'd2, 8'h00, 8'h77, 1'b0);
        @(posedge PCLK); #1;
        PSEL_i    = 1'b1;
        PENABLE_i = 1'b0;
        PWRITE_i  = 1'b1;
        PADDR_i   = 3'd2;
        PWDATA_i  = 8'h99;
        @(posedge PCLK); #1;
        PENABLE_i = 1'b1;
        #2 PRESET_n = 1'b0;
        @(posedge PCLK); #1;
        PSEL_i    = 1'b0;
        PENABLE_i = 1'b0;
        PWRITE_i  = 1'b0;
        @(posedge PCLK); #1;
        PRESET_n = 1'b1;
        xfer("rd_br_post_rst",  1'b0, 3'd2, 8'h00, 8'h00, 1'b0);
        xfer("rd_cr1_post_rst", 1'b0, 3'd0, 8'h00, 8'h04, 1'b0);
        xfer("rd_dr_post_rst",  1'b0, 3'd5, 8'h00, 8'h00, 1'b0);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge PCLK);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending responses required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
